// File: rtl/sd_cic_decimator_if.sv
// Sample stream bundle between the sigma-delta filter, the CIC decimator and the sample consumer.
interface sd_cic_decimator_if #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 24
);
  logic                    in_valid;
  logic signed [IN_W-1:0]  in_data;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    overrun;
  logic                    busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_data, out_valid, overrun, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_data, out_valid, overrun, busy
  );
endinterface

// File: rtl/sd_cic_decimator.sv
// N-stage CIC decimator by 2**LOG2R with a serial comb engine and a 2-entry output buffer.
// Optional ROUND_EN macro: round-half-up on the output word instead of truncation.
module sd_cic_decimator #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 24,
  parameter int N     = 3,
  parameter int LOG2R = 6
) (
  input logic               clk,
  input logic               reset,
  sd_cic_decimator_if.slave bus
);
  localparam int ACC_W = IN_W + N * LOG2R;
  localparam int SH    = ACC_W - OUT_W;
  localparam int KW    = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, COMB, PUSH} state_e;

  function automatic logic signed [OUT_W-1:0] round_out(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-1:0] t;
`ifdef ROUND_EN
    t = v + (ACC_W'(1) << (SH - 1));
`else
    t = v;
`endif
    return t[ACC_W-1:SH];
  endfunction

  logic signed [ACC_W-1:0] integ_q [N];
  logic signed [ACC_W-1:0] integ_d [N];
  logic [LOG2R-1:0]        dec_q;
  logic                    take_last;

  state_e                  state_q, state_d;
  logic [KW-1:0]           stage_q;
  logic signed [ACC_W-1:0] x_q;
  logic signed [ACC_W-1:0] dly_q [N];
  logic signed [ACC_W-1:0] comb_c;
  logic                    snap_en, comb_en, push;

  logic signed [OUT_W-1:0] mem_q [2];
  logic signed [OUT_W-1:0] last_q;
  logic signed [OUT_W-1:0] res;
  logic                    rd_q, wr_ptr;
  logic [1:0]              cnt_q;
  logic                    overrun_q, pop, full, accept, drop;

  // Integrator cascade: each stage adds the freshly updated value of the stage before it.
  always_comb begin
    integ_d[0] = integ_q[0] + {{(ACC_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
    for (int k = 1; k < N; k++) begin
      integ_d[k] = integ_q[k] + integ_d[k-1];
    end
  end

  assign take_last = bus.in_valid & (&dec_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) integ_q[k] <= '0;
      dec_q <= '0;
    end else if (bus.in_valid) begin
      for (int k = 0; k < N; k++) integ_q[k] <= integ_d[k];
      dec_q <= dec_q + LOG2R'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take_last) state_d = COMB;
      COMB:    if (stage_q == KW'(N - 1)) state_d = PUSH;
      PUSH:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    snap_en = (state_q == IDLE) & take_last;
    comb_en = (state_q == COMB);
    push    = (state_q == PUSH);
    bus.busy = (state_q != IDLE);
  end

  // Serial comb: one differentiator stage per clock, working in place on x_q.
  assign comb_c = x_q - dly_q[stage_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      stage_q <= '0;
      for (int k = 0; k < N; k++) dly_q[k] <= '0;
    end else if (snap_en) begin
      x_q     <= integ_d[N-1];
      stage_q <= '0;
    end else if (comb_en) begin
      x_q            <= comb_c;
      dly_q[stage_q] <= x_q;
      stage_q        <= stage_q + KW'(1);
    end
  end

  // Output buffer: a push into a full buffer is only accepted when the head leaves on the same edge.
  assign res    = round_out(x_q);
  assign pop    = (cnt_q != 2'd0) & bus.out_ready;
  assign full   = (cnt_q == 2'd2);
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;
  assign wr_ptr = rd_q ^ cnt_q[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      last_q    <= '0;
      rd_q      <= 1'b0;
      cnt_q     <= 2'd0;
      overrun_q <= 1'b0;
    end else begin
      if (accept) mem_q[wr_ptr] <= res;
      if (pop) begin
        last_q <= mem_q[rd_q];
        rd_q   <= ~rd_q;
      end
      cnt_q <= cnt_q + 2'(accept) - 2'(pop);
      if (drop) overrun_q <= 1'b1;
    end
  end

  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.out_data  = bus.out_valid ? mem_q[rd_q] : last_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_sd_cic_decimator.sv
// Scoreboard bench for sd_cic_decimator: a reference CIC model queues expected words at stimulus time.
module tb_sd_cic_decimator;
  localparam int IN_W  = 24;
  localparam int OUT_W = 24;
  localparam int N     = 3;
  localparam int LOG2R = 6;
  localparam int R     = 64;
  localparam int ACC_W = IN_W + N * LOG2R;
  localparam int SH    = ACC_W - OUT_W;

  logic clk = 1'b0;
  logic reset = 1'b1;

  sd_cic_decimator_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus();

  sd_cic_decimator #(.IN_W(IN_W), .OUT_W(OUT_W), .N(N), .LOG2R(LOG2R)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int     vectors = 0;
  int     miscompares = 0;
  longint sb_q[$];
  longint m_int[N];
  longint m_dly[N];
  int     m_cnt;
  int     outs_seen;
  logic   const_en;
  longint const_val;
  longint first_out;

  task automatic check_val(input string tag, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic longint wrapw(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic longint mdl_out(input longint c);
    longint t;
    t = c;
`ifdef ROUND_EN
    t = wrapw(t + (longint'(1) <<< (SH - 1)), ACC_W);
`endif
    return wrapw(t >>> SH, OUT_W);
  endfunction

  task automatic model_in(input longint x);
    longint v, c;
    m_int[0] = wrapw(m_int[0] + x, ACC_W);
    for (int k = 1; k < N; k++) m_int[k] = wrapw(m_int[k] + m_int[k-1], ACC_W);
    m_cnt++;
    if (m_cnt == R) begin
      m_cnt = 0;
      v = m_int[N-1];
      for (int k = 0; k < N; k++) begin
        c = wrapw(v - m_dly[k], ACC_W);
        m_dly[k] = v;
        v = c;
      end
      sb_q.push_back(mdl_out(v));
    end
  endtask

  task automatic sb_clear();
    sb_q.delete();
    for (int k = 0; k < N; k++) begin
      m_int[k] = 0;
      m_dly[k] = 0;
    end
    m_cnt = 0;
    outs_seen = 0;
    const_en = 1'b0;
    first_out = -12345;
  endtask

  task automatic drive(input logic v, input longint x);
    @(posedge clk); #1;
    bus.in_valid = v;
    bus.in_data  = v ? IN_W'(x) : '0;
    if (v) model_in(wrapw(x, IN_W));
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    sb_clear();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out_data", $signed(bus.out_data), 0);
    check_val("rst_overrun", bus.overrun, 0);
    check_val("rst_busy", bus.busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) check_val("sb_pending", sb_q.size(), 1);
      else check_val("sb_data", $signed(bus.out_data), sb_q.pop_front());
      if (outs_seen == 0) first_out = $signed(bus.out_data);
      if (const_en && outs_seen >= 3) check_val("settled", $signed(bus.out_data), const_val);
      outs_seen++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy_n;
    longint exp_first;

    // Constant 1000, continuous input
    do_reset();
    const_en = 1'b1; const_val = 1000;
    for (int i = 0; i < 6 * R; i++) drive(1'b1, 1000);
    idle(10);
    check_val("t1_outputs", outs_seen, 6);
    check_val("t1_sb_left", sb_q.size(), 0);

    // First output for constant 4
    do_reset();
    for (int i = 0; i < R; i++) drive(1'b1, 4);
    idle(10);
`ifdef ROUND_EN
    exp_first = 1;
`else
    exp_first = 0;
`endif
    check_val("t2_first_out", first_out, exp_first);
    check_val("t2_outputs", outs_seen, 1);

    // Negative and positive full-scale constants
    do_reset();
    const_en = 1'b1; const_val = -1;
    for (int i = 0; i < 5 * R; i++) drive(1'b1, -1);
    idle(10);
    check_val("t3_neg_outputs", outs_seen, 5);
    do_reset();
    const_en = 1'b1; const_val = 8388607;
    for (int i = 0; i < 5 * R; i++) drive(1'b1, 8388607);
    idle(10);
    check_val("t3_pos_outputs", outs_seen, 5);

    // Backpressure: two buffered, third dropped
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3 * R; i++) drive(1'b1, longint'($signed($urandom)) >>> 8);
    idle(10);
    void'(sb_q.pop_back());
    check_val("t4_overrun", bus.overrun, 1);
    check_val("t4_valid_held", bus.out_valid, 1);
    check_val("t4_head", $signed(bus.out_data), sb_q[0]);
    idle(3);
    check_val("t4_head_hold", $signed(bus.out_data), sb_q[0]);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    idle(6);
    check_val("t4_valid_drained", bus.out_valid, 0);
    check_val("t4_overrun_sticky", bus.overrun, 1);
    check_val("t4_outputs", outs_seen, 2);
    check_val("t4_sb_left", sb_q.size(), 0);

    // Latency and busy width from the edge taking the 64th input
    do_reset();
    for (int i = 0; i < R; i++) drive(1'b1, 500);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    busy_n = bus.busy ? 1 : 0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      if (bus.out_valid && lat == 0) lat = e;
      if (bus.busy) busy_n++;
    end
    check_val("t5_latency", lat, N + 1);
    check_val("t5_busy_cycles", busy_n, N + 1);
    idle(4);
    check_val("t5_sb_left", sb_q.size(), 0);

    // Reset while the comb engine is active, then gapped input
    do_reset();
    for (int i = 0; i < R; i++) drive(1'b1, 1000);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check_val("t6_busy_pre", bus.busy, 1);
    reset = 1'b1;
    #1;
    check_val("t6_rst_valid", bus.out_valid, 0);
    check_val("t6_rst_data", $signed(bus.out_data), 0);
    check_val("t6_rst_overrun", bus.overrun, 0);
    check_val("t6_rst_busy", bus.busy, 0);
    sb_clear();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(10);
    check_val("t6_no_stale", outs_seen, 0);
    const_en = 1'b1; const_val = 1000;
    for (int i = 0; i < 5 * R * 3; i++) drive((i % 3) == 0, 1000);
    idle(10);
    check_val("t6_gap_outputs", outs_seen, 5);
    check_val("t6_sb_left", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
